pc_fetch_unit: RTL and testbench

//   Program-counter register and next-PC logic for the single-cycle processor.

---
 rtl/pc_fetch_unit.sv | 138 +++++++++++++
 tb/tb_pc_fetch_unit.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// Program counter and next-PC resolution for the single-cycle core.
// Drives the synchronous instruction ROM address and resolves bne/blt/bex/j/jal/jr.
module pc_fetch_unit #(
    parameter int          ADDR_W   = 12,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              stall_i,
    input  logic [4:0]        opcode_i,
    input  logic              branch_i,
    input  logic              jump_i,
    input  logic              jal_i,
    input  logic              jr_i,
    input  logic [31:0]       rd_val_i,
    input  logic [31:0]       rs_val_i,
    input  logic [31:0]       rstatus_val_i,
    input  logic [16:0]       imm_i,
    input  logic [26:0]       target_i,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [31:0]       pc_o,
    output logic [31:0]       link_addr_o,
    output logic              insn_valid_o,
    output logic              redirect_o
);

    typedef enum logic [1:0] {
        BOOT = 2'b00,
        RUN  = 2'b01,
        HOLD = 2'b10
    } state_e;

    localparam logic [4:0] OPC_BNE = 5'b00010;
    localparam logic [4:0] OPC_BLT = 5'b00110;
    localparam logic [4:0] OPC_BEX = 5'b10110;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        insn_valid_q, insn_valid_d;

    logic [31:0] pc_plus1;
    logic [31:0] br_target;
    logic [31:0] jmp_target;
    logic [31:0] next_pc;
    logic        taken;
    logic        is_bex;

    assign pc_plus1   = pc_q + 32'd1;
    assign br_target  = pc_plus1 + {{15{imm_i[16]}}, imm_i};
    assign jmp_target = {5'b0, target_i};

    always_comb begin
        taken  = 1'b0;
        is_bex = 1'b0;
        case (opcode_i)
            OPC_BNE: taken = (rd_val_i != rs_val_i);
            OPC_BLT: taken = ($signed(rd_val_i) < $signed(rs_val_i));
            OPC_BEX: begin
                taken  = (rstatus_val_i != 32'd0);
                is_bex = 1'b1;
            end
            default: taken = 1'b0;
        endcase
    end

    // jal always arrives with Jump set; it is folded in so a lone jal still jumps.
    always_comb begin
        next_pc = pc_plus1;
        if (insn_valid_q) begin
            if (jr_i)
                next_pc = rd_val_i;
            else if (jump_i || jal_i)
                next_pc = jmp_target;
            else if (branch_i && taken)
                next_pc = is_bex ? jmp_target : br_target;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= BOOT;
            pc_q         <= RESET_PC;
            insn_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            insn_valid_q <= insn_valid_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        insn_valid_d = insn_valid_q;
        case (state_q)
            BOOT: begin
                state_d      = RUN;
                insn_valid_d = 1'b1;
            end
            RUN: begin
                if (stall_i)
                    state_d = HOLD;
                else
                    pc_d = next_pc;
            end
            HOLD: begin
                if (!stall_i) begin
                    state_d = RUN;
                    pc_d    = next_pc;
                end
            end
            default: begin
                state_d      = BOOT;
                pc_d         = RESET_PC;
                insn_valid_d = 1'b0;
            end
        endcase
    end

    // The fetch address is the PC that will be loaded on the coming edge, so the
    // ROM word lines up with pc; on the HOLD release cycle that is next_pc.
    always_comb begin
        imem_addr_o = pc_q[ADDR_W-1:0];
        redirect_o  = insn_valid_q & (jump_i | jal_i | jr_i | (branch_i & taken));
        case (state_q)
            RUN, HOLD: begin
                if (!stall_i)
                    imem_addr_o = next_pc[ADDR_W-1:0];
            end
            default: imem_addr_o = pc_q[ADDR_W-1:0];
        endcase
    end

    assign pc_o         = pc_q;
    assign link_addr_o  = pc_plus1;
    assign insn_valid_o = insn_valid_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed scoreboard bench for pc_fetch_unit: stimulus pushes expected outputs,
// a negedge monitor pops and compares them.
module tb_pc_fetch_unit;

    localparam int ADDR_W = 12;

    typedef struct {
        logic        rstN;
        logic        stall;
        logic [4:0]  opc;
        logic        br;
        logic        jmp;
        logic        jl;
        logic        jrr;
        logic [31:0] rd;
        logic [31:0] rs;
        logic [31:0] rstat;
        logic [16:0] imm;
        logic [26:0] tgt;
    } stim_t;

    typedef struct {
        logic [31:0]       pc;
        logic [ADDR_W-1:0] imem;
        logic              valid;
        logic              redirect;
        logic              chkImem;
        int                id;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              stall;
    logic [4:0]        opcode;
    logic              branch;
    logic              jump;
    logic              jal;
    logic              jr;
    logic [31:0]       rdVal;
    logic [31:0]       rsVal;
    logic [31:0]       rstatusVal;
    logic [16:0]       imm;
    logic [26:0]       target;
    logic [ADDR_W-1:0] imemAddr;
    logic [31:0]       pc;
    logic [31:0]       linkAddr;
    logic              insnValid;
    logic              redirect;

    exp_t expQ[$];
    int   vectorCount = 0;
    int   missCount   = 0;
    int   stimId      = 0;

    pc_fetch_unit #(.ADDR_W(ADDR_W), .RESET_PC(32'h0)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .stall_i       (stall),
        .opcode_i      (opcode),
        .branch_i      (branch),
        .jump_i        (jump),
        .jal_i         (jal),
        .jr_i          (jr),
        .rd_val_i      (rdVal),
        .rs_val_i      (rsVal),
        .rstatus_val_i (rstatusVal),
        .imm_i         (imm),
        .target_i      (target),
        .imem_addr_o   (imemAddr),
        .pc_o          (pc),
        .link_addr_o   (linkAddr),
        .insn_valid_o  (insnValid),
        .redirect_o    (redirect)
    );

    always #5 clk = ~clk;

    function automatic stim_t idle();
        stim_t s;
        s.rstN  = 1'b1;
        s.stall = 1'b0;
        s.opc   = 5'b00000;
        s.br    = 1'b0;
        s.jmp   = 1'b0;
        s.jl    = 1'b0;
        s.jrr   = 1'b0;
        s.rd    = 32'h0;
        s.rs    = 32'h0;
        s.rstat = 32'h0;
        s.imm   = 17'h0;
        s.tgt   = 27'h0;
        return s;
    endfunction

    function automatic stim_t jmpStim(input logic [26:0] t);
        stim_t s;
        s     = idle();
        s.jmp = 1'b1;
        s.tgt = t;
        return s;
    endfunction

    function automatic stim_t brStim(input logic [4:0] o, input logic [31:0] a,
                                     input logic [31:0] b, input logic [31:0] st,
                                     input logic [16:0] n, input logic [26:0] t);
        stim_t s;
        s       = idle();
        s.br    = 1'b1;
        s.opc   = o;
        s.rd    = a;
        s.rs    = b;
        s.rstat = st;
        s.imm   = n;
        s.tgt   = t;
        return s;
    endfunction

    function automatic exp_t mkExp(input logic [31:0] p, input logic [ADDR_W-1:0] a,
                                   input logic v, input logic r);
        exp_t e;
        e.pc       = p;
        e.imem     = a;
        e.valid    = v;
        e.redirect = r;
        e.chkImem  = 1'b1;
        e.id       = 0;
        return e;
    endfunction

    // Called at posedge+1: drive one cycle of inputs, queue expectation, wait an edge.
    task automatic applyStimulus(input stim_t s, input exp_t e);
        rst_n      = s.rstN;
        stall      = s.stall;
        opcode     = s.opc;
        branch     = s.br;
        jump       = s.jmp;
        jal        = s.jl;
        jr         = s.jrr;
        rdVal      = s.rd;
        rsVal      = s.rs;
        rstatusVal = s.rstat;
        imm        = s.imm;
        target     = s.tgt;
        stimId++;
        e.id = stimId;
        expQ.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input exp_t e);
        logic [31:0] expLink;
        expLink = e.pc + 32'd1;
        vectorCount++;
        if (pc !== e.pc) begin
            missCount++;
            $display("[TB] FAIL v%0d pc: got %h want %h", e.id, pc, e.pc);
        end
        vectorCount++;
        if (insnValid !== e.valid) begin
            missCount++;
            $display("[TB] FAIL v%0d insn_valid: got %b want %b", e.id, insnValid, e.valid);
        end
        vectorCount++;
        if (redirect !== e.redirect) begin
            missCount++;
            $display("[TB] FAIL v%0d redirect: got %b want %b", e.id, redirect, e.redirect);
        end
        vectorCount++;
        if (linkAddr !== expLink) begin
            missCount++;
            $display("[TB] FAIL v%0d link_addr: got %h want %h", e.id, linkAddr, expLink);
        end
        if (e.chkImem) begin
            vectorCount++;
            if (imemAddr !== e.imem) begin
                missCount++;
                $display("[TB] FAIL v%0d imem_addr: got %h want %h", e.id, imemAddr, e.imem);
            end
        end
    endtask

    always @(negedge clk) begin
        if (expQ.size() > 0)
            checkOutput(expQ.pop_front());
    end

    initial begin
        stim_t s;
        exp_t  e;

        s = idle();
        rst_n = 1'b1; stall = 1'b0; opcode = 5'b0; branch = 1'b0; jump = 1'b0;
        jal = 1'b0; jr = 1'b0; rdVal = 32'h0; rsVal = 32'h0; rstatusVal = 32'h0;
        imm = 17'h0; target = 27'h0;
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1;
        $display("[TB] reset and boot");

        s = idle(); s.rstN = 1'b0;
        applyStimulus(s, mkExp(32'h0, 12'h000, 1'b0, 1'b0));
        applyStimulus(s, mkExp(32'h0, 12'h000, 1'b0, 1'b0));
        applyStimulus(idle(), mkExp(32'h0, 12'h000, 1'b0, 1'b0));
        applyStimulus(idle(), mkExp(32'h0, 12'h001, 1'b1, 1'b0));
        applyStimulus(idle(), mkExp(32'h1, 12'h002, 1'b1, 1'b0));
        applyStimulus(idle(), mkExp(32'h2, 12'h003, 1'b1, 1'b0));

        $display("[TB] bne / blt");
        applyStimulus(jmpStim(27'd10), mkExp(32'd3, 12'd10, 1'b1, 1'b1));
        applyStimulus(brStim(5'b00010, 32'd5, 32'd7, 32'd0, 17'h1FFFE, 27'd0),
                      mkExp(32'd10, 12'd9, 1'b1, 1'b1));
        applyStimulus(jmpStim(27'd10), mkExp(32'd9, 12'd10, 1'b1, 1'b1));
        applyStimulus(brStim(5'b00010, 32'd5, 32'd5, 32'd0, 17'h1FFFE, 27'd0),
                      mkExp(32'd10, 12'd11, 1'b1, 1'b0));
        applyStimulus(brStim(5'b00110, 32'hFFFF_FFFF, 32'd1, 32'd0, 17'd5, 27'd0),
                      mkExp(32'd11, 12'd17, 1'b1, 1'b1));
        applyStimulus(brStim(5'b00110, 32'd1, 32'hFFFF_FFFF, 32'd0, 17'd5, 27'd0),
                      mkExp(32'd17, 12'd18, 1'b1, 1'b0));

        $display("[TB] jal / jr");
        applyStimulus(jmpStim(27'd20), mkExp(32'd18, 12'd20, 1'b1, 1'b1));
        s = jmpStim(27'h100); s.jl = 1'b1;
        applyStimulus(s, mkExp(32'd20, 12'h100, 1'b1, 1'b1));
        s = jmpStim(27'h7); s.jrr = 1'b1; s.rd = 32'h0000_1042;
        applyStimulus(s, mkExp(32'h100, 12'h042, 1'b1, 1'b1));

        $display("[TB] bex and stall");
        applyStimulus(brStim(5'b10110, 32'd0, 32'd0, 32'd0, 17'd3, 27'h55),
                      mkExp(32'h1042, 12'h043, 1'b1, 1'b0));
        s = brStim(5'b10110, 32'd0, 32'd0, 32'd3, 17'd3, 27'h55);
        s.stall = 1'b1;
        for (int i = 0; i < 3; i++)
            applyStimulus(s, mkExp(32'h1043, 12'h043, 1'b1, 1'b1));
        s.stall = 1'b0;
        e = mkExp(32'h1043, 12'h000, 1'b1, 1'b1);
        e.chkImem = 1'b0;
        applyStimulus(s, e);
        applyStimulus(jmpStim(27'h55), mkExp(32'h55, 12'h055, 1'b1, 1'b1));
        applyStimulus(idle(), mkExp(32'h55, 12'h056, 1'b1, 1'b0));

        $display("[TB] reset during hold");
        applyStimulus(jmpStim(27'h30), mkExp(32'h56, 12'h030, 1'b1, 1'b1));
        s = idle(); s.stall = 1'b1;
        applyStimulus(s, mkExp(32'h30, 12'h030, 1'b1, 1'b0));
        applyStimulus(s, mkExp(32'h30, 12'h030, 1'b1, 1'b0));
        s = jmpStim(27'h77); s.stall = 1'b1; s.rstN = 1'b0;
        applyStimulus(s, mkExp(32'h0, 12'h000, 1'b0, 1'b0));
        applyStimulus(idle(), mkExp(32'h0, 12'h000, 1'b0, 1'b0));
        applyStimulus(idle(), mkExp(32'h0, 12'h001, 1'b1, 1'b0));
        applyStimulus(idle(), mkExp(32'h1, 12'h002, 1'b1, 1'b0));

        for (int i = 0; i < 10 && expQ.size() != 0; i++)
            @(negedge clk);
        #1;
        vectorCount++;
        if (expQ.size() != 0) begin
            missCount++;
            $display("[TB] FAIL drain: got %0d pending want 0", expQ.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
